// File: rtl/echo_block_sequencer.sv
// Block sequencer for the FTDI echo datapath: read one block, echo it back in
// full, clear the datapath counters, repeat. Idle or disabled partial blocks are flushed.
module echo_block_sequencer #(
    parameter int BLOCK_SIZE   = 512,
    parameter int CT_W         = 10,
    parameter int IDLE_TIMEOUT = 1024,
    parameter int TO_W         = 11
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            en,
    input  logic            rd_strobe,
    input  logic            wr_strobe,
    output logic            rd_en,
    output logic            tx_en,
    output logic            data_wr_valid,
    output logic            ct_clear,
    output logic            tx_done,
    output logic [CT_W-1:0] rx_ct,
    output logic [CT_W-1:0] tx_ct,
    output logic [1:0]      state,
    output logic            protocol_err
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_READ  = 2'd1,
        S_WRITE = 2'd2,
        S_CLEAR = 2'd3
    } state_t;

    localparam logic [CT_W-1:0] CT_ONE     = CT_W'(1);
    localparam logic [CT_W-1:0] BLOCK_LAST = CT_W'(BLOCK_SIZE - 1);
    localparam logic [TO_W-1:0] TO_ONE     = TO_W'(1);
    localparam logic [TO_W-1:0] TO_LAST    = TO_W'(IDLE_TIMEOUT - 1);

    state_t          state_q, state_d;
    logic [CT_W-1:0] rx_ct_q, rx_ct_d;
    logic [CT_W-1:0] tx_ct_q, tx_ct_d;
    logic [TO_W-1:0] to_ct_q, to_ct_d;
    logic            err_q, err_d;
    logic [CT_W-1:0] rx_ct_inc, tx_ct_inc;
    logic            tx_caught_up;

    assign rx_ct_inc    = rx_ct_q + CT_ONE;
    assign tx_ct_inc    = tx_ct_q + CT_ONE;
    assign tx_caught_up = (tx_ct_q == rx_ct_q);

    // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latches).
    always_comb begin
        state_d = state_q;
        rx_ct_d = rx_ct_q;
        tx_ct_d = tx_ct_q;
        to_ct_d = to_ct_q;
        err_d   = err_q;

        if (rd_strobe && state_q != S_READ)
            err_d = 1'b1;
        if (wr_strobe && (state_q != S_WRITE || tx_caught_up))
            err_d = 1'b1;

        unique case (state_q)
            S_IDLE: begin
                to_ct_d = '0;
                if (en)
                    state_d = S_READ;
            end
            S_READ: begin
                // A strobe always beats a timeout; a strobe taken with en low is flushed, not dropped.
                if (rd_strobe) begin
                    rx_ct_d = rx_ct_inc;
                    to_ct_d = '0;
                    if (rx_ct_q == BLOCK_LAST || !en)
                        state_d = S_WRITE;
                end else if (rx_ct_q == '0) begin
                    to_ct_d = '0;
                    if (!en)
                        state_d = S_IDLE;
                end else if (!en || to_ct_q == TO_LAST) begin
                    to_ct_d = '0;
                    state_d = S_WRITE;
                end else begin
                    to_ct_d = to_ct_q + TO_ONE;
                end
            end
            S_WRITE: begin
                to_ct_d = '0;
                if (wr_strobe && !tx_caught_up) begin
                    tx_ct_d = tx_ct_inc;
                    if (tx_ct_inc == rx_ct_q)
                        state_d = S_CLEAR;
                end
            end
            S_CLEAR: begin
                rx_ct_d = '0;
                tx_ct_d = '0;
                to_ct_d = '0;
                state_d = en ? S_READ : S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them update together at the edge.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            rx_ct_q <= '0;
            tx_ct_q <= '0;
            to_ct_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rx_ct_q <= rx_ct_d;
            tx_ct_q <= tx_ct_d;
            to_ct_q <= to_ct_d;
            err_q   <= err_d;
        end
    end

    // Outputs decode registered state only, so no input reaches an output combinationally.
    assign rd_en         = (state_q == S_READ);
    assign tx_en         = (state_q == S_WRITE);
    assign data_wr_valid = (state_q == S_WRITE) && (tx_ct_q < rx_ct_q);
    assign ct_clear      = (state_q == S_CLEAR);
    assign tx_done       = (state_q == S_CLEAR);
    assign rx_ct         = rx_ct_q;
    assign tx_ct         = tx_ct_q;
    assign state         = state_q;
    assign protocol_err  = err_q;

endmodule

// File: tb/tb_echo_block_sequencer.sv
// Self-checking bench for echo_block_sequencer: vector table, directed corner
// sequences, and a randomized run against a behavioural reference model.
module tb_echo_block_sequencer;

    localparam int CT_W         = 10;
    localparam int BLOCK_SIZE   = 512;
    localparam int IDLE_TIMEOUT = 1024;

    localparam int M_IDLE  = 0;
    localparam int M_READ  = 1;
    localparam int M_WRITE = 2;
    localparam int M_CLEAR = 3;

    logic            clock = 1'b0;
    logic            reset = 1'b1;
    logic            en = 1'b0;
    logic            rd_strobe = 1'b0;
    logic            wr_strobe = 1'b0;
    logic            rd_en, tx_en, data_wr_valid, ct_clear, tx_done, protocol_err;
    logic [CT_W-1:0] rx_ct, tx_ct;
    logic [1:0]      state;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: phase, bytes held, bytes echoed, silent cycles, sticky error.
    int   m_mode = M_IDLE;
    int   m_rx   = 0;
    int   m_tx   = 0;
    int   m_idle = 0;
    logic m_err  = 1'b0;

    echo_block_sequencer dut (
        .clock         (clock),
        .reset         (reset),
        .en            (en),
        .rd_strobe     (rd_strobe),
        .wr_strobe     (wr_strobe),
        .rd_en         (rd_en),
        .tx_en         (tx_en),
        .data_wr_valid (data_wr_valid),
        .ct_clear      (ct_clear),
        .tx_done       (tx_done),
        .rx_ct         (rx_ct),
        .tx_ct         (tx_ct),
        .state         (state),
        .protocol_err  (protocol_err)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       en, rd, wr;
        logic [1:0] st;
        int         rx, tx;
        logic       rd_en, tx_en, dwv, clr, done, err;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    function automatic logic [27:0] obs();
        return {state, rx_ct, tx_ct, rd_en, tx_en, data_wr_valid, ct_clear, tx_done, protocol_err};
    endfunction

    function automatic logic [27:0] model_obs();
        return {2'(m_mode), CT_W'(m_rx), CT_W'(m_tx), m_mode == M_READ, m_mode == M_WRITE,
                (m_mode == M_WRITE) && (m_tx < m_rx), m_mode == M_CLEAR, m_mode == M_CLEAR, m_err};
    endfunction

    function automatic logic [27:0] vec_obs(input vec_t v);
        return {v.st, CT_W'(v.rx), CT_W'(v.tx), v.rd_en, v.tx_en, v.dwv, v.clr, v.done, v.err};
    endfunction

    task automatic model_step(input logic e, input logic r, input logic w, input logic rs);
        if (rs) begin
            m_mode = M_IDLE; m_rx = 0; m_tx = 0; m_idle = 0; m_err = 1'b0;
            return;
        end
        if (r && m_mode != M_READ) m_err = 1'b1;
        if (w && (m_mode != M_WRITE || m_tx == m_rx)) m_err = 1'b1;
        case (m_mode)
            M_IDLE: if (e) m_mode = M_READ;
            M_READ: begin
                if (r) begin
                    m_rx++;
                    m_idle = 0;
                    if (m_rx == BLOCK_SIZE || !e) m_mode = M_WRITE;
                end else if (m_rx == 0) begin
                    if (!e) m_mode = M_IDLE;
                end else begin
                    m_idle++;
                    if (!e || m_idle == IDLE_TIMEOUT) m_mode = M_WRITE;
                end
            end
            M_WRITE: begin
                if (w && m_tx < m_rx) begin
                    m_tx++;
                    if (m_tx == m_rx) m_mode = M_CLEAR;
                end
            end
            default: begin
                m_rx = 0; m_tx = 0; m_idle = 0;
                m_mode = e ? M_READ : M_IDLE;
            end
        endcase
    endtask

    // Drive one cycle of inputs, advance the model at the edge, sample 1 time unit later.
    task automatic step(input logic e, input logic r, input logic w);
        en = e; rd_strobe = r; wr_strobe = w;
        @(posedge clock);
        model_step(e, r, w, reset);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        step(1'b0, 1'b0, 1'b0);
        reset = 1'b0;
    endtask

    task automatic idle_steps(input int n, input logic e);
        for (int i = 0; i < n; i++) step(e, 1'b0, 1'b0);
    endtask

    task automatic rd_steps(input int n);
        for (int i = 0; i < n; i++) step(1'b1, 1'b1, 1'b0);
    endtask

    task automatic wr_steps(input int n, input logic e);
        for (int i = 0; i < n; i++) step(e, 1'b0, 1'b1);
    endtask

    initial begin
        vec_t vecs[14];
        int   bad;
        int   n;

        // en rd wr | state rx tx | rd_en tx_en dwv clr done err
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 2'd1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 1'b0, 2'd1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{1'b1, 1'b1, 1'b0, 2'd1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[3]  = '{1'b1, 1'b0, 1'b0, 2'd1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[4]  = '{1'b0, 1'b0, 1'b0, 2'd2, 2, 0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 2'd2, 2, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 1'b0, 2'd2, 2, 1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 2'd3, 2, 2, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 2'd0, 0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 2'd1, 0, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[11] = '{1'b1, 1'b1, 1'b0, 2'd1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 2'd1, 1, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[13] = '{1'b1, 1'b1, 1'b0, 2'd1, 2, 0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        do_reset();
        check("reset_state", obs(), 28'h0);
        foreach (vecs[i]) begin
            step(vecs[i].en, vecs[i].rd, vecs[i].wr);
            check($sformatf("vec%0d", i), obs(), vec_obs(vecs[i]));
        end

        // Full block: 512 in, 512 out, one clear cycle, straight back to READ.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        check("en_to_rd_en", {state, rd_en}, {2'd1, 1'b1});
        bad = 0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            step(1'b1, 1'b1, 1'b0);
            if (i < BLOCK_SIZE - 1 && rd_en !== 1'b1) bad++;
        end
        check("rd_en_held", bad, 0);
        check("full_to_write", {state, rx_ct, rd_en, tx_en}, {2'd2, 10'd512, 1'b0, 1'b1});
        bad = 0;
        for (int i = 0; i < BLOCK_SIZE; i++) begin
            if (data_wr_valid !== 1'b1) bad++;
            step(1'b1, 1'b0, 1'b1);
        end
        check("dwv_held", bad, 0);
        check("full_clear", {state, ct_clear, tx_done, data_wr_valid}, {2'd3, 1'b1, 1'b1, 1'b0});
        step(1'b1, 1'b0, 1'b0);
        check("full_reread", {state, rd_en, rx_ct, tx_ct, protocol_err}, {2'd1, 1'b1, 20'd0, 1'b0});

        // Timeout flush of a 5-byte block.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        rd_steps(5);
        n = 0;
        while (state !== 2'd2 && n < 2 * IDLE_TIMEOUT) begin
            step(1'b1, 1'b0, 1'b0);
            n++;
        end
        check("timeout_cycles", n, IDLE_TIMEOUT);
        check("timeout_rx", rx_ct, 5);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 1'b1);
            if (i < 4) step(1'b1, 1'b0, 1'b0);
        end
        check("timeout_done", {state, tx_done, tx_ct}, {2'd3, 1'b1, 10'd5});
        step(1'b1, 1'b0, 1'b0);
        check("timeout_reread", {state, rx_ct, protocol_err}, {2'd1, 10'd0, 1'b0});

        // Strobe lands on the cycle the timeout would fire.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        rd_steps(3);
        idle_steps(IDLE_TIMEOUT - 1, 1'b1);
        check("bnd_before", {state, rx_ct}, {2'd1, 10'd3});
        step(1'b1, 1'b1, 1'b0);
        check("bnd_strobe_wins", {state, rx_ct}, {2'd1, 10'd4});
        idle_steps(IDLE_TIMEOUT - 1, 1'b1);
        check("bnd_restart", state, 2'd1);
        step(1'b1, 1'b0, 1'b0);
        check("bnd_fire", {state, rx_ct}, {2'd2, 10'd4});

        // en low mid-read flushes the partial block; WRITE completes with en low.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        rd_steps(7);
        step(1'b0, 1'b0, 1'b0);
        check("en0_flush", {state, rx_ct, tx_ct, protocol_err}, {2'd2, 10'd7, 10'd0, 1'b0});
        step(1'b0, 1'b1, 1'b0);
        check("rd_in_write", {protocol_err, rx_ct, state}, {1'b1, 10'd7, 2'd2});
        wr_steps(7, 1'b0);
        check("en0_done", {state, tx_done, tx_ct}, {2'd3, 1'b1, 10'd7});
        step(1'b0, 1'b0, 1'b0);
        check("en0_idle", {state, rd_en, tx_en, rx_ct, protocol_err}, {2'd0, 2'b00, 10'd0, 1'b1});

        // wr in READ, then reset clears the flag, then wr with tx_ct==rx_ct.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        rd_steps(2);
        step(1'b1, 1'b0, 1'b1);
        check("wr_in_read", {protocol_err, tx_ct, rx_ct, state}, {1'b1, 10'd0, 10'd2, 2'd1});
        do_reset();
        check("err_reset", protocol_err, 1'b0);
        step(1'b1, 1'b0, 1'b0);
        rd_steps(2);
        step(1'b0, 1'b0, 1'b0);
        wr_steps(2, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        check("wr_extra", {protocol_err, state}, {1'b1, 2'd1});
        idle_steps(20, 1'b1);
        check("err_sticky", protocol_err, 1'b1);

        // Reset mid-WRITE overrides everything, strobes included.
        do_reset();
        step(1'b1, 1'b0, 1'b0);
        rd_steps(200);
        step(1'b0, 1'b0, 1'b0);
        wr_steps(100, 1'b1);
        check("pre_reset_tx", {state, tx_ct}, {2'd2, 10'd100});
        reset = 1'b1;
        step(1'b1, 1'b1, 1'b1);
        reset = 1'b0;
        check("reset_in_write", obs(), 28'h0);

        // Randomized run compared every cycle against the model.
        do_reset();
        for (int seg = 0; seg < 6; seg++) begin
            int rd_pct;
            int bad_pct;
            rd_pct  = (seg == 2 || seg == 5) ? 0 : (seg == 1 ? 90 : 40);
            bad_pct = (seg >= 3) ? 2 : 0;
            for (int c = 0; c < 1500; c++) begin
                logic e, r, w;
                e = ($urandom_range(0, 29) != 0);
                if (seg == 2 && c < 4) r = (m_mode == M_READ);
                else if (m_mode == M_READ) r = ($urandom_range(0, 99) < rd_pct);
                else r = ($urandom_range(0, 99) < bad_pct);
                if (m_mode == M_WRITE) w = ($urandom_range(0, 99) < 60);
                else w = ($urandom_range(0, 99) < bad_pct);
                reset = ($urandom_range(0, 799) == 0);
                step(e, r, w);
                reset = 1'b0;
                check($sformatf("rand_s%0d_c%0d", seg, c), obs(), model_obs());
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
